audio_decim_buffer: RTL and testbench
=====================================

AUDIO_DECIM_BUFFER -- requirements
Module: audio_decim_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 The block SHALL have parameter DECIM, default 4, decimation factor, legal range 1..16 (200 kHz FIR output -> 50 kHz audio).
REQ-003 The block SHALL have parameter DEPTH, default 8, FIFO depth in entries, power of two, range 2..64.
REQ-004 The block SHALL have parameter GAIN_SHIFT, default 0, arithmetic left shift applied to kept samples, range 0..7.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid_i  input  1  one-cycle strobe; data_i holds a new low-pass-filtered sample.
REQ-008 data_i  input  WIDTH  signed filtered sample from the FIR stage (16.0 format).
REQ-009 out_ready_i  input  1  downstream (audio serializer) accepts the head sample.
REQ-010 clear_ovf_i  input  1  clears the sticky overflow flag.
REQ-011 out_valid_o  output  1  FIFO non-empty; data_o is valid.
REQ-012 data_o  output  WIDTH  signed head-of-FIFO sample (first-word-fall-through).
REQ-013 level_o  output  log2(DEPTH)+1  number of entries currently stored.
REQ-014 overflow_o  output  1  sticky; a kept sample was dropped because the FIFO was full.

Function
REQ-015 A decimation counter SHALL count 0..DECIM-1, advancing only on in_valid_i and wrapping from DECIM-1 to 0.
REQ-016 A sample SHALL be kept when in_valid_i=1 and the counter equals 0; all other samples SHALL be discarded; the first strobe after reset is always kept.
REQ-017 With DECIM=1, every strobed sample SHALL be kept.
REQ-018 The kept sample SHALL be data_i shifted left by GAIN_SHIFT and saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap-around is permitted.
REQ-019 A kept sample SHALL be pushed in the same cycle as its strobe; out_valid_o and level_o SHALL reflect it on the next cycle (1-cycle latency when empty).
REQ-020 A pop SHALL occur when out_valid_o=1 and out_ready_i=1; data_o SHALL then advance to the next entry on the following cycle.
REQ-021 data_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-022 data_o SHALL be 0 while the FIFO is empty.
REQ-023 out_ready_i while empty SHALL have no effect.
REQ-024 When a push and a pop occur in the same cycle, level_o SHALL be unchanged and ordering SHALL be preserved.
REQ-025 When the FIFO is full, a push SHALL be accepted only if a pop occurs in the same cycle; otherwise the sample SHALL be dropped and stored contents left untouched.
REQ-026 overflow_o SHALL go high the cycle after a dropped push and SHALL hold until clear_ovf_i=1 or rst.
REQ-027 If a drop and clear_ovf_i occur in the same cycle, overflow_o SHALL be 1 (set wins).
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 level_o SHALL never exceed DEPTH or go below 0.
REQ-030 A dropped sample SHALL still advance the decimation counter.
REQ-031 Strobes on consecutive cycles SHALL be fully supported.

Reset
REQ-032 On rst=1 the block SHALL zero the decimation counter, both pointers and level_o, and SHALL drive out_valid_o=0, data_o=0 and overflow_o=0 on the next cycle.
REQ-033 rst SHALL override all simultaneous push, pop and clear events.
REQ-034 Reset mid-stream SHALL discard all stored samples.
REQ-035 The first strobe after reset release SHALL be kept.

Verification
REQ-036 Decimation: DECIM=4; strobe data_i=1,2,3,...,12 every 5 cycles with out_ready_i=1 -> outputs exactly 1, 5, 9 in order.
REQ-037 Saturation: GAIN_SHIFT=2; data_i=10000 -> 32767; data_i=-10000 -> -32768; data_i=100 -> 400.
REQ-038 Overflow: DECIM=1, DEPTH=8, out_ready_i=0; push 10 samples -> level_o=8, overflow_o=1; drain yields the first 8 samples only; clear_ovf_i -> overflow_o=0.
REQ-039 Full with simultaneous push and pop: level_o=8, push and pop in the same cycle -> level_o stays 8, overflow_o stays 0, order intact.
REQ-040 Backpressure: toggle out_ready_i randomly -> data_o stable whenever valid and not ready; output sequence matches a reference model.
REQ-041 Reset mid-operation: rst asserted with level_o=5 -> next cycle level_o=0, out_valid_o=0, data_o=0; the next strobe is kept.

Source files
------------

// File: rtl/audio_decim_if.sv
// Handshake bundle between the FIR stage, the decimating buffer and the audio serializer.
// The slave modport is the buffer itself; the master modport is whoever drives the samples and readiness.
interface audio_decim_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_ready;
    logic                    clear_ovf;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_data;
    logic [LW-1:0]           level;
    logic                    overflow;

    modport master (
        output in_valid, in_data, out_ready, clear_ovf,
        input  out_valid, out_data, level, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready, clear_ovf,
        output out_valid, out_data, level, overflow
    );
endinterface

// File: rtl/audio_decim_buffer.sv
// Keeps every DECIM-th filtered sample, applies a saturating gain shift and queues it in a
// first-word-fall-through FIFO with a sticky overflow flag for dropped samples.
module audio_decim_buffer #(
    parameter int WIDTH      = 16,
    parameter int DECIM      = 4,
    parameter int DEPTH      = 8,
    parameter int GAIN_SHIFT = 0
) (
    input logic         clk,
    input logic         rst,
    audio_decim_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int XW = WIDTH + 8;

    // Saturation bounds held in the widened domain so the shifted value compares directly.
    localparam logic signed [XW-1:0] SAT_MAX = {{9{1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {{9{1'b1}}, {(WIDTH-1){1'b0}}};

    logic [CW-1:0]        dec_cnt;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] shifted;
    logic [WIDTH-1:0]     sat_data;
    logic                 keep;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 drop;

    always_comb begin
        ext      = {{8{bus.in_data[WIDTH-1]}}, bus.in_data};
        shifted  = ext <<< GAIN_SHIFT;
        sat_data = shifted[WIDTH-1:0];
        if (shifted > SAT_MAX) begin
            sat_data = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_data = SAT_MIN[WIDTH-1:0];
        end
    end

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign keep  = bus.in_valid && (dec_cnt == '0);
    assign pop   = !empty && bus.out_ready;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push  = keep && (!full || pop);
    assign drop  = keep && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (bus.in_valid) begin
            dec_cnt <= (dec_cnt == CW'(DECIM - 1)) ? '0 : dec_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= sat_data;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (bus.clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];
    assign bus.level     = level;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_audio_decim_buffer.sv
// Directed bench for audio_decim_buffer: instance A decimates by 4 with unity gain,
// instance B keeps every sample with a gain shift of 2; a queue model predicts every output.
module tb_audio_decim_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    audio_decim_if #(.WIDTH(16), .DEPTH(8)) ifa ();
    audio_decim_if #(.WIDTH(16), .DEPTH(8)) ifb ();

    audio_decim_buffer #(.WIDTH(16), .DECIM(4), .DEPTH(8), .GAIN_SHIFT(0)) u_a (
        .clk(clk), .rst(rst_a), .bus(ifa.slave)
    );
    audio_decim_buffer #(.WIDTH(16), .DECIM(1), .DEPTH(8), .GAIN_SHIFT(2)) u_b (
        .clk(clk), .rst(rst_b), .bus(ifb.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int q[$];
    int got[$];
    int cnt   = 0;
    int movf  = 0;
    bit hold  = 1'b0;
    int held  = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int d, input int sh);
        int t;
        t = d * (1 << sh);
        if (t > 32767) return 32767;
        if (t < -32768) return -32768;
        return t;
    endfunction

    // One clock: check outputs against the model, drive inputs, advance the model.
    task automatic cycle(input int sel, input bit v, input int d, input bit r, input bit c, input bit rs);
        int  ov, od, lv, of;
        bit  popm, keep, drop;
        @(negedge clk);
        if (sel == 0) begin
            ov = int'(ifa.out_valid); od = int'($signed(ifa.out_data));
            lv = int'(ifa.level);     of = int'(ifa.overflow);
        end else begin
            ov = int'(ifb.out_valid); od = int'($signed(ifb.out_data));
            lv = int'(ifb.level);     of = int'(ifb.overflow);
        end
        chk("valid", ov, (q.size() != 0) ? 1 : 0);
        chk("level", lv, q.size());
        chk("overflow", of, movf);
        if (q.size() == 0) chk("empty_data", od, 0);
        if (hold && ov == 1) chk("stable", od, held);
        popm = (q.size() != 0) && r && !rs;
        if (popm) begin
            got.push_back(od);
            chk("data", od, q.pop_front());
        end
        hold = (ov == 1) && !r;
        held = od;
        if (sel == 0) begin
            ifa.in_valid = v; ifa.in_data = 16'(d); ifa.out_ready = r; ifa.clear_ovf = c; rst_a = rs;
        end else begin
            ifb.in_valid = v; ifb.in_data = 16'(d); ifb.out_ready = r; ifb.clear_ovf = c; rst_b = rs;
        end
        if (rs) begin
            q.delete();
            cnt  = 0;
            movf = 0;
            hold = 1'b0;
        end else begin
            keep = v && (cnt == 0);
            if (v) cnt = (cnt + 1) % ((sel == 0) ? 4 : 1);
            drop = keep && (q.size() >= 8);
            if (keep && !drop) q.push_back(sat(d, (sel == 0) ? 0 : 2));
            if (drop) movf = 1;
            else if (c) movf = 0;
        end
        @(posedge clk);
    endtask

    task automatic drain(input int sel);
        for (int i = 0; i < 40 && q.size() != 0; i++) cycle(sel, 0, 0, 1, 0, 0);
        chk("drain_done", q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.in_valid = 0; ifa.in_data = '0; ifa.out_ready = 0; ifa.clear_ovf = 0;
        ifb.in_valid = 0; ifb.in_data = '0; ifb.out_ready = 0; ifb.clear_ovf = 0;
        rst_a = 1; rst_b = 1;
        repeat (3) @(posedge clk);
        rst_a = 0; rst_b = 0;

        // reset state of both instances
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // decimation by 4: strobes 1..12 every 5 cycles -> 1, 5, 9
        got.delete();
        for (int k = 1; k <= 12; k++) begin
            cycle(0, 1, k, 1, 0, 0);
            repeat (4) cycle(0, 0, 0, 1, 0, 0);
        end
        drain(0);
        chk("dec_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("dec_0", got[0], 1);
            chk("dec_1", got[1], 5);
            chk("dec_2", got[2], 9);
        end

        // reset mid-stream with level 5, with strobe, pop and clear asserted alongside
        for (int k = 1; k <= 17; k++) cycle(0, 1, k, 0, 0, 0);
        #1 chk("rst_pre_level", int'(ifa.level), 5);
        cycle(0, 1, 55, 1, 1, 1);
        #1;
        chk("rst_level", int'(ifa.level), 0);
        chk("rst_valid", int'(ifa.out_valid), 0);
        chk("rst_data", int'($signed(ifa.out_data)), 0);
        cycle(0, 1, 77, 0, 0, 0);
        #1 chk("rst_first_level", int'(ifa.level), 1);
        got.delete();
        drain(0);
        chk("rst_first_count", got.size(), 1);
        if (got.size() == 1) chk("rst_first_data", got[0], 77);

        // switch model to instance B
        cnt = 0; hold = 1'b0; movf = 0; q.delete();

        // saturating gain of x4
        got.delete();
        cycle(1, 1, 10000, 0, 0, 0);
        cycle(1, 1, -10000, 0, 0, 0);
        cycle(1, 1, 100, 0, 0, 0);
        drain(1);
        chk("sat_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("sat_pos", got[0], 32767);
            chk("sat_neg", got[1], -32768);
            chk("sat_mid", got[2], 400);
        end

        // overflow: 10 pushes into 8 entries without reads
        got.delete();
        for (int k = 1; k <= 10; k++) cycle(1, 1, k, 0, 0, 0);
        #1;
        chk("ovf_level", int'(ifb.level), 8);
        chk("ovf_flag", int'(ifb.overflow), 1);
        drain(1);
        chk("ovf_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) chk("ovf_data", got[i], 4 * (i + 1));
        #1 chk("ovf_sticky", int'(ifb.overflow), 1);
        cycle(1, 0, 0, 0, 1, 0);
        #1 chk("ovf_cleared", int'(ifb.overflow), 0);

        // full with simultaneous push and pop, then drop racing a clear
        for (int k = 21; k <= 28; k++) cycle(1, 1, k, 0, 0, 0);
        #1 chk("full_level", int'(ifb.level), 8);
        cycle(1, 1, 99, 1, 0, 0);
        #1;
        chk("full_pp_level", int'(ifb.level), 8);
        chk("full_pp_ovf", int'(ifb.overflow), 0);
        cycle(1, 1, 50, 0, 1, 0);
        #1 chk("set_wins", int'(ifb.overflow), 1);
        cycle(1, 0, 0, 0, 1, 0);
        got.delete();
        drain(1);
        chk("full_count", got.size(), 8);
        if (got.size() == 8) begin
            chk("full_head", got[0], 88);
            chk("full_tail", got[7], 396);
        end

        // random backpressure and strobes
        for (int i = 0; i < 120; i++) begin
            cycle(1, bit'($urandom_range(0, 1)), int'($urandom_range(0, 20000)) - 10000,
                  bit'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        cycle(1, 0, 0, 1, 1, 0);
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
